rs_latch_checker: RTL
=====================

// Module: rs_latch_checker
// PURPOSE
//  Clocked monitor for an RS latch. It samples the latch inputs (s, r) and outputs (q, nq)
//  and tracks the expected latch state with its own model. It flags forbidden input
//  combinations, output mismatches and q/nq complement violations, and counts errors.
//  It sits beside any rslatch instance, in a bench or as an on-chip checker.
// PARAMETERS
//  ACTIVE_LOW  0  1: s/r assert at 0 (NAND latch); 0: s/r assert at 1 (NOR latch)
//  SETTLE      3  clock cycles allowed for q/nq to follow an input change, range 1..15
//  CNT_W       8  width of the saturating error counters
// PORTS
//  clk        in   1      sampling clock
//  rst_n      in   1      asynchronous reset, active low
//  s          in   1      latch set input (asynchronous to clk)
//  r          in   1      latch reset input (asynchronous to clk)
//  q          in   1      latch output
//  nq         in   1      latch complementary output
//  clr        in   1      synchronous clear of counters and sticky flags
//  exp_q      out  1      model's expected q (valid when exp_vld=1)
//  exp_vld    out  1      model state is known (not UNKNOWN/FORBID)
//  forbid     out  1      1-cycle pulse on entry to the forbidden input state
//  mismatch   out  1      1-cycle pulse: q!=exp_q or q==nq after SETTLE expired
//  err_sticky out  1      set by any forbid/mismatch pulse, held until clr or reset
//  forbid_cnt out  CNT_W  saturating count of forbid pulses
//  mism_cnt   out  CNT_W  saturating count of mismatch pulses
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=UNKNOWN; synchronizers and settle timer cleared.
//  - s, r, q, nq each pass through a 2-flop synchronizer; all logic uses the synced values.
//  - Normalize: sa = s^ACTIVE_LOW, ra = r^ACTIVE_LOW (1 = asserted).
//  - FSM states: UNKNOWN, SET, RESET, FORBID. Transitions are evaluated every cycle:
//    sa&~ra -> SET; ~sa&ra -> RESET; sa&ra -> FORBID; ~sa&~ra -> hold current state.
//    FORBID with both released -> hold FORBID (output undefined, exp_vld=0).
//    Leaving FORBID: via a single asserted input only.
//  - exp_q = (state==SET); exp_vld = state in {SET, RESET}; both are registered (1 cycle
//    after the synced input change).
//  - forbid pulses on the cycle the FSM enters FORBID; it does not repeat while in FORBID.
//  - Settle timer: loads SETTLE on any state change and decrements to 0. Checks are made
//    only when the timer is 0 and exp_vld=1:
//    mismatch when q_s!=exp_q or q_s==nq_s. It re-pulses every cycle the condition persists.
//  - Counters saturate at 2^CNT_W-1; no wrap.
//  - Simultaneous pulse and clr in one cycle: clr wins. Counters and sticky go to 0 and
//    the pulse is not counted.
//  - Reset mid-check: everything returns to the reset values at once; the settle window
//    restarts from UNKNOWN.
// CONFIGURATION
//  RSCHK_RACE_DETECT_EN defined: adds output race (1 bit). It pulses when sa and ra both
//   deassert in the same synced cycle while in FORBID. The FSM then goes to UNKNOWN,
//   which counts as a state change. race is OR'd into err_sticky; it is not counted.
//  Not defined: no race port; FORBID releases to hold FORBID as above.
// TESTING
//  1. Reset with rst_n=0 during toggling inputs -> all outputs 0, FSM UNKNOWN until a
//     single input asserts.
//  2. ACTIVE_LOW=0: s=1,r=0 with a model latch (q=1,nq=0) -> exp_q=1, exp_vld=1 three
//     cycles after s rises; no mismatch.
//  3. s=1,r=1 -> forbid pulses once, forbid_cnt=1, err_sticky=1. Then s=0,r=0 ->
//     FSM stays FORBID, exp_vld=0.
//  4. Stuck q=0 after set, SETTLE=3 -> mismatch first pulses 3 cycles after the state
//     change and repeats each cycle; mism_cnt counts.
//  5. Drive 300 forbid entries with CNT_W=8 -> forbid_cnt stops at 255. clr coincident
//     with a forbid pulse -> count=0.
//  6. With RSCHK_RACE_DETECT_EN: from s=r=1, release both in the same cycle -> race=1 for
//     1 cycle, exp_vld=0, err_sticky=1.

Source files
------------

// File: rtl/rs_latch_checker.sv
// rs_latch_checker: clocked monitor beside an RS latch; tracks the expected
// latch state, flags forbidden inputs, output mismatches, and counts errors.
//
// Ports:
//   clk, rst_n  sampling clock, async active-low reset
//   s, r        latch inputs (async to clk)
//   q, nq       latch outputs (async to clk)
//   clr         sync clear of counters and sticky flag
//   exp_q       model's expected q (valid when exp_vld)
//   exp_vld     model state is SET or RESET
//   forbid      pulse on entry to the forbidden input state
//   mismatch    pulse while q/nq disagree with the model after settling
//   err_sticky  any forbid/mismatch (and race) since last clr/reset
//   forbid_cnt  saturating forbid pulse count
//   mism_cnt    saturating mismatch pulse count
//   race        (RSCHK_RACE_DETECT_EN only) simultaneous release from FORBID
//
// Optional feature macro: RSCHK_RACE_DETECT_EN
module rs_latch_checker #(
  parameter logic ACTIVE_LOW = 1'b0,
  parameter int   SETTLE     = 3,
  parameter int   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             nq,
  input  logic             clr,
  output logic             exp_q,
  output logic             exp_vld,
  output logic             forbid,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] forbid_cnt,
  output logic [CNT_W-1:0] mism_cnt
`ifdef RSCHK_RACE_DETECT_EN
  ,
  output logic             race
`endif
);

  localparam logic [1:0] ST_UNKNOWN = 2'd0;
  localparam logic [1:0] ST_SET     = 2'd1;
  localparam logic [1:0] ST_RESET   = 2'd2;
  localparam logic [1:0] ST_FORBID  = 2'd3;

  localparam logic [3:0] SETTLE_V = 4'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic r_s_m, r_s_s;
  logic r_r_m, r_r_s;
  logic r_q_m, r_q_s;
  logic r_nq_m, r_nq_s;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       w_chg;
  logic       w_sa;
  logic       w_ra;

  logic       r_exp_q;
  logic       r_exp_vld;
  logic       r_forbid;
  logic [3:0] r_timer;
  logic       w_mismatch;
  logic       w_err;

  logic             r_sticky;
  logic [CNT_W-1:0] r_fcnt;
  logic [CNT_W-1:0] r_mcnt;

  // s/r synchronizers clear to the idle (deasserted) level so a
  // NAND-style latch does not look forbidden straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_m  <= ACTIVE_LOW;
      r_s_s  <= ACTIVE_LOW;
      r_r_m  <= ACTIVE_LOW;
      r_r_s  <= ACTIVE_LOW;
      r_q_m  <= 1'b0;
      r_q_s  <= 1'b0;
      r_nq_m <= 1'b0;
      r_nq_s <= 1'b0;
    end else begin
      r_s_m  <= s;
      r_s_s  <= r_s_m;
      r_r_m  <= r;
      r_r_s  <= r_r_m;
      r_q_m  <= q;
      r_q_s  <= r_q_m;
      r_nq_m <= nq;
      r_nq_s <= r_nq_m;
    end
  end

  assign w_sa = r_s_s ^ ACTIVE_LOW;
  assign w_ra = r_r_s ^ ACTIVE_LOW;

`ifdef RSCHK_RACE_DETECT_EN
  logic r_sa_d;
  logic r_ra_d;
  logic r_race;
  logic w_race;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa_d <= 1'b0;
      r_ra_d <= 1'b0;
      r_race <= 1'b0;
    end else begin
      r_sa_d <= w_sa;
      r_ra_d <= w_ra;
      r_race <= w_race;
    end
  end

  // Both inputs dropping together leaves the real latch
  // in a race: its final state cannot be predicted.
  assign w_race = (r_state == ST_FORBID) & r_sa_d & r_ra_d
                & ~w_sa & ~w_ra;
  assign race   = r_race;
`endif

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (w_sa & ~w_ra): w_next = ST_SET;
      (~w_sa & w_ra): w_next = ST_RESET;
      (w_sa & w_ra):  w_next = ST_FORBID;
      default: begin
`ifdef RSCHK_RACE_DETECT_EN
        if (w_race) w_next = ST_UNKNOWN;
`endif
      end
    endcase
  end

  assign w_chg = (w_next != r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_UNKNOWN;
      r_exp_q   <= 1'b0;
      r_exp_vld <= 1'b0;
      r_forbid  <= 1'b0;
      r_timer   <= 4'd0;
    end else begin
      r_state   <= w_next;
      r_exp_q   <= (w_next == ST_SET);
      r_exp_vld <= (w_next == ST_SET) | (w_next == ST_RESET);
      r_forbid  <= (w_next == ST_FORBID) & (r_state != ST_FORBID);
      if (w_chg)
        r_timer <= SETTLE_V;
      else if (r_timer != 4'd0)
        r_timer <= r_timer - 4'd1;
    end
  end

  // Outputs are judged only once the settle window has run out.
  assign w_mismatch = (r_timer == 4'd0) & r_exp_vld
                    & ((r_q_s != r_exp_q) | (r_q_s == r_nq_s));

`ifdef RSCHK_RACE_DETECT_EN
  assign w_err = r_forbid | w_mismatch | r_race;
`else
  assign w_err = r_forbid | w_mismatch;
`endif

  // A pulse is accounted at the edge that ends it, so a clr on
  // that same edge discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_fcnt   <= '0;
      r_mcnt   <= '0;
    end else if (clr) begin
      r_sticky <= 1'b0;
      r_fcnt   <= '0;
      r_mcnt   <= '0;
    end else begin
      if (w_err)
        r_sticky <= 1'b1;
      if (r_forbid && (r_fcnt != CNT_MAX))
        r_fcnt <= r_fcnt + CNT_ONE;
      if (w_mismatch && (r_mcnt != CNT_MAX))
        r_mcnt <= r_mcnt + CNT_ONE;
    end
  end

  assign exp_q      = r_exp_q;
  assign exp_vld    = r_exp_vld;
  assign forbid     = r_forbid;
  assign mismatch   = w_mismatch;
  assign err_sticky = r_sticky;
  assign forbid_cnt = r_fcnt;
  assign mism_cnt   = r_mcnt;

endmodule
